// File: rtl/player_sprite_plotter_pkg.sv
// Shared constants and FSM state type for the player sprite plotter.
package player_sprite_plotter_pkg;

  localparam int          SPRITE_SIZE = 5;
  localparam int          SPRITE_HALF = 2;
  localparam logic [23:0] BG_COLOUR   = 24'h000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ERASE  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/player_sprite_plotter_if.sv
// Pixel-write bus from the plotter to the VGA adapter.
interface player_sprite_plotter_if;

  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [23:0] vga_colour;
  logic        plot;

  modport master (output vga_x, output vga_y, output vga_colour, output plot);
  modport slave  (input  vga_x, input  vga_y, input  vga_colour, input  plot);

endinterface

// File: rtl/sprite_scan_counter.sv
// Row-major dx/dy walker over the sprite box; last marks the final pixel.
module sprite_scan_counter
  import player_sprite_plotter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);

  localparam logic [2:0] MAX_IDX = 3'(SPRITE_SIZE - 1);

  logic [2:0] dx_q, dx_d;
  logic [2:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clear) begin
      dx_d = 3'd0;
      dy_d = 3'd0;
    end else if (en) begin
      if (dx_q == MAX_IDX) begin
        dx_d = 3'd0;
        dy_d = (dy_q == MAX_IDX) ? 3'd0 : dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q <= 3'd0;
      dy_q <= 3'd0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == MAX_IDX) && (dy_q == MAX_IDX);

endmodule

// File: rtl/player_sprite_plotter.sv
// Moves the player heart: erases the old 5x5 box (if one was drawn), then
// draws the new one, writing one pixel per cycle to the VGA adapter.
module player_sprite_plotter
  import player_sprite_plotter_pkg::*;
#(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int INIT_X   = 80,
  parameter int INIT_Y   = 60
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [7:0]                     new_x,
  input  logic [6:0]                     new_y,
  input  logic [7:0]                     pix_red,
  input  logic [7:0]                     pix_green,
  input  logic [7:0]                     pix_blue,
  output logic [7:0]                     player_x,
  output logic [6:0]                     player_y,
  output logic [7:0]                     scan_x,
  output logic [6:0]                     scan_y,
  player_sprite_plotter_if.master        vga,
  output logic                           busy,
  output logic                           done,
  output state_t                         state_dbg,
  output logic [2:0]                     scan_dx_dbg,
  output logic [2:0]                     scan_dy_dbg
);

  localparam logic [8:0] X_LIM   = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM   = 8'(SCREEN_H);
  localparam logic [2:0] DX_MAX  = 3'(SPRITE_SIZE - 1);
  localparam logic [7:0] HALF_X  = 8'(SPRITE_HALF);
  localparam logic [6:0] HALF_Y  = 7'(SPRITE_HALF);
  localparam logic [7:0] ROW_REW = 8'(SPRITE_SIZE - 1);

  state_t      state_q, state_d;
  logic        drawn_q, drawn_d;
  logic [7:0]  tgt_x_q, tgt_x_d;
  logic [6:0]  tgt_y_q, tgt_y_d;
  logic [7:0]  player_x_q, player_x_d;
  logic [6:0]  player_y_q, player_y_d;
  logic [7:0]  scan_x_q, scan_x_d;
  logic [6:0]  scan_y_q, scan_y_d;
  logic [7:0]  vga_x_q, vga_x_d;
  logic [6:0]  vga_y_q, vga_y_d;
  logic [23:0] vga_colour_q, vga_colour_d;
  logic        plot_q, plot_d;

  logic        cnt_clear, cnt_en, cnt_last;
  logic [2:0]  cnt_dx, cnt_dy;
  logic        scanning;

  sprite_scan_counter u_scan (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (cnt_en),
    .dx    (cnt_dx),
    .dy    (cnt_dy),
    .last  (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    drawn_d      = drawn_q;
    tgt_x_d      = tgt_x_q;
    tgt_y_d      = tgt_y_q;
    player_x_d   = player_x_q;
    player_y_d   = player_y_q;
    scan_x_d     = scan_x_q;
    scan_y_d     = scan_y_q;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    scanning     = (state_q == ERASE) || (state_q == DRAW);
    // The output stage captures the pixel being scanned this cycle, colour included.
    vga_x_d      = scan_x_q;
    vga_y_d      = scan_y_q;
    vga_colour_d = (state_q == DRAW) ? {pix_red, pix_green, pix_blue} : BG_COLOUR;
    plot_d       = scanning && ({1'b0, scan_x_q} < X_LIM) && ({1'b0, scan_y_q} < Y_LIM);

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_x_d   = new_x;
          tgt_y_d   = new_y;
          cnt_clear = 1'b1;
          if (drawn_q) begin
            state_d  = ERASE;
            scan_x_d = player_x_q - HALF_X;
            scan_y_d = player_y_q - HALF_Y;
          end else begin
            state_d    = DRAW;
            drawn_d    = 1'b1;
            player_x_d = new_x;
            player_y_d = new_y;
            scan_x_d   = new_x - HALF_X;
            scan_y_d   = new_y - HALF_Y;
          end
        end
      end
      ERASE, DRAW: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          if (state_q == ERASE) begin
            state_d    = DRAW;
            drawn_d    = 1'b1;
            cnt_clear  = 1'b1;
            player_x_d = tgt_x_q;
            player_y_d = tgt_y_q;
            scan_x_d   = tgt_x_q - HALF_X;
            scan_y_d   = tgt_y_q - HALF_Y;
          end else begin
            state_d = FINISH;
          end
        end else if (cnt_dx == DX_MAX) begin
          scan_x_d = scan_x_q - ROW_REW;
          scan_y_d = scan_y_q + 7'd1;
        end else begin
          scan_x_d = scan_x_q + 8'd1;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      drawn_q      <= 1'b0;
      tgt_x_q      <= 8'd0;
      tgt_y_q      <= 7'd0;
      player_x_q   <= 8'(INIT_X);
      player_y_q   <= 7'(INIT_Y);
      scan_x_q     <= 8'd0;
      scan_y_q     <= 7'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 24'd0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      drawn_q      <= drawn_d;
      tgt_x_q      <= tgt_x_d;
      tgt_y_q      <= tgt_y_d;
      player_x_q   <= player_x_d;
      player_y_q   <= player_y_d;
      scan_x_q     <= scan_x_d;
      scan_y_q     <= scan_y_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
    end
  end

  assign player_x       = player_x_q;
  assign player_y       = player_y_q;
  assign scan_x         = scan_x_q;
  assign scan_y         = scan_y_q;
  assign vga.vga_x      = vga_x_q;
  assign vga.vga_y      = vga_y_q;
  assign vga.vga_colour = vga_colour_q;
  assign vga.plot       = plot_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == FINISH);
  assign state_dbg      = state_q;
  assign scan_dx_dbg    = cnt_dx;
  assign scan_dy_dbg    = cnt_dy;

endmodule

// File: tb/tb_player_sprite_plotter.sv
// Bench for player_sprite_plotter: a heart renderer model feeds colours, and
// a queue of expected VGA writes is checked against every plot pulse.
module tb_player_sprite_plotter;
  import player_sprite_plotter_pkg::*;

  localparam int SW = 160;
  localparam int SH = 120;
  localparam logic [7:0] IX = 8'd80;
  localparam logic [6:0] IY = 7'd60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] new_x = 8'd0;
  logic [6:0] new_y = 7'd0;
  logic [7:0] pix_red, pix_green, pix_blue;
  logic [7:0] player_x, scan_x;
  logic [6:0] player_y, scan_y;
  logic       busy, done;
  state_t     state_dbg;
  logic [2:0] scan_dx_dbg, scan_dy_dbg;

  player_sprite_plotter_if vga_bus();

  player_sprite_plotter #(
    .SCREEN_W(SW), .SCREEN_H(SH), .INIT_X(80), .INIT_Y(60)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .new_x(new_x), .new_y(new_y),
    .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
    .player_x(player_x), .player_y(player_y), .scan_x(scan_x), .scan_y(scan_y),
    .vga(vga_bus), .busy(busy), .done(done), .state_dbg(state_dbg),
    .scan_dx_dbg(scan_dx_dbg), .scan_dy_dbg(scan_dy_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic heart_bit(input logic [7:0] rx, input logic [6:0] ry);
    logic [4:0] row;
    case (ry)
      7'd0: row = 5'b01010;
      7'd1: row = 5'b11111;
      7'd2: row = 5'b11111;
      7'd3: row = 5'b01110;
      7'd4: row = 5'b00100;
      default: row = 5'b00000;
    endcase
    if (rx > 8'd4) return 1'b0;
    return row[rx[2:0]];
  endfunction

  // Heart renderer model: red on heart pixels, with position-coded green/blue.
  logic [7:0] rel_x;
  logic [6:0] rel_y;
  logic       hit;
  assign rel_x     = scan_x - player_x + 8'd2;
  assign rel_y     = scan_y - player_y + 7'd2;
  assign hit       = heart_bit(rel_x, rel_y);
  assign pix_red   = hit ? 8'hFF : 8'h00;
  assign pix_green = hit ? scan_x : 8'h00;
  assign pix_blue  = hit ? {1'b0, scan_y} : 8'h00;

  int checks = 0;
  int failures = 0;
  logic [38:0] exp_q[$];
  logic        model_drawn = 1'b0;
  logic [7:0]  model_px = IX;
  logic [6:0]  model_py = IY;

  task automatic push_pixels(input logic [7:0] cx, input logic [6:0] cy, input bit draw,
                             output int n);
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] col;
    n = 0;
    for (int dy = 0; dy < 5; dy++) begin
      for (int dx = 0; dx < 5; dx++) begin
        x = cx - 8'd2 + 8'(dx);
        y = cy - 7'd2 + 7'(dy);
        if (x < 8'(SW) && y < 7'(SH)) begin
          col = (draw && heart_bit(8'(dx), 7'(dy))) ? {8'hFF, x, 1'b0, y} : 24'h000000;
          exp_q.push_back({x, y, col});
          n++;
        end
      end
    end
  endtask

  task automatic run_move(input logic [7:0] nx, input logic [6:0] ny, input int abort_at,
                          input bit noise, input int exp_draw_plots, input string name);
    int n_e, n_d, exp_done, plots, done_at;
    logic [38:0] got, want;
    n_e = 0;
    exp_q.delete();
    if (model_drawn) push_pixels(model_px, model_py, 1'b0, n_e);
    push_pixels(nx, ny, 1'b1, n_d);
    checks++;
    if (n_d !== exp_draw_plots) begin
      failures++;
      $display("FAIL %s draw_count: model %0d required %0d", name, n_d, exp_draw_plots);
    end
    exp_done = model_drawn ? 51 : 26;
    @(negedge clk);
    start = 1'b1; new_x = nx; new_y = ny;
    plots = 0; done_at = 0;
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (abort_at != 0 && cyc == abort_at + 1) begin
        checks++;
        if (vga_bus.plot !== 1'b0 || busy !== 1'b0 || player_x !== IX || done !== 1'b0) begin
          failures++;
          $display("FAIL %s abort: plot=%b busy=%b done=%b player_x=%0d required 0 0 0 %0d",
                   name, vga_bus.plot, busy, done, player_x, IX);
        end
        reset = 1'b0;
        exp_q.delete();
        model_drawn = 1'b0; model_px = IX; model_py = IY;
        return;
      end
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("FAIL %s busy: cycle %0d got %b required 1", name, cyc, busy);
      end
      if (vga_bus.plot === 1'b1) begin
        plots++;
        got = {vga_bus.vga_x, vga_bus.vga_y, vga_bus.vga_colour};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_plot: got %h required none", name, got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            failures++;
            $display("FAIL %s plot: cycle %0d got %h required %h", name, cyc, got, want);
          end
        end
      end
      if (noise && cyc == 10) begin
        start = 1'b1; new_x = nx + 8'd7; new_y = ny + 7'd3;
      end
      if (abort_at != 0 && cyc == abort_at) reset = 1'b1;
      if (done === 1'b1) begin
        done_at = cyc;
        if (noise) start = 1'b1;
        break;
      end
    end
    checks++;
    if (done_at != exp_done) begin
      failures++;
      $display("FAIL %s done_cycle: got k+%0d required k+%0d", name, done_at, exp_done);
    end
    checks++;
    if (exp_q.size() != 0 || plots != n_e + n_d) begin
      failures++;
      $display("FAIL %s plot_count: got %0d required %0d", name, plots, n_e + n_d);
    end
    checks++;
    if (player_x !== nx || player_y !== ny) begin
      failures++;
      $display("FAIL %s player: got (%0d,%0d) required (%0d,%0d)", name, player_x, player_y,
               nx, ny);
    end
    for (int i = 0; i < (noise ? 4 : 1); i++) begin
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || vga_bus.plot !== 1'b0) begin
        failures++;
        $display("FAIL %s after_done: busy=%b done=%b plot=%b required 0 0 0", name, busy,
                 done, vga_bus.plot);
      end
    end
    model_drawn = 1'b1; model_px = nx; model_py = ny;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (vga_bus.plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: plot=%b busy=%b done=%b required 0 0 0", vga_bus.plot, busy, done);
    end
    checks++;
    if (vga_bus.vga_x !== 8'd0 || vga_bus.vga_y !== 7'd0 || vga_bus.vga_colour !== 24'd0) begin
      failures++;
      $display("FAIL reset_vga: got %h/%h/%h required 0/0/0", vga_bus.vga_x, vga_bus.vga_y,
               vga_bus.vga_colour);
    end
    checks++;
    if (scan_x !== 8'd0 || scan_y !== 7'd0) begin
      failures++;
      $display("FAIL reset_scan: got (%0d,%0d) required (0,0)", scan_x, scan_y);
    end
    checks++;
    if (player_x !== IX || player_y !== IY) begin
      failures++;
      $display("FAIL reset_player: got (%0d,%0d) required (%0d,%0d)", player_x, player_y, IX, IY);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      failures++;
      $display("FAIL reset_state: got %0d required %0d", state_dbg, IDLE);
    end
    model_drawn = 1'b0; model_px = IX; model_py = IY;
  endtask

  task automatic test_first_move();
    run_move(8'd90, 7'd50, 0, 1'b0, 25, "first_move");
  endtask

  task automatic test_second_move();
    run_move(8'd100, 7'd70, 0, 1'b0, 25, "second_move");
  endtask

  task automatic test_clip_low();
    run_move(8'd0, 7'd0, 0, 1'b0, 9, "clip_low");
  endtask

  task automatic test_clip_high();
    run_move(8'd159, 7'd119, 0, 1'b0, 9, "clip_high");
  endtask

  task automatic test_ignored_starts();
    run_move(8'd60, 7'd40, 0, 1'b1, 25, "ignored_starts");
  endtask

  task automatic test_same_centre();
    run_move(8'd60, 7'd40, 0, 1'b0, 25, "same_centre");
  endtask

  task automatic test_reset_mid_move();
    run_move(8'd30, 7'd30, 30, 1'b0, 25, "reset_mid_move");
    run_move(8'd40, 7'd20, 0, 1'b0, 25, "after_abort");
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_second_move();
    test_clip_low();
    test_clip_high();
    test_ignored_starts();
    test_same_centre();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
